// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg
// Shared types and helpers for the frame_sync preamble detector/framer.
//   state_t  : framer state (SEARCH, PEAK, PAYLOAD)
//   score_w  : width needed to hold a correlation score over len positions
package frame_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    PEAK    = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  function automatic int score_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/frame_sync_corr.sv
// frame_sync_corr
// Combinational masked correlator.
//   window  : MAX_LEN samples, bit 0 newest
//   pattern : reference preamble, aligned to window
//   mask    : 1 = position participates in the score
//   s       : number of masked positions where window equals pattern
//   s_inv   : number of masked positions where window differs from pattern
module frame_sync_corr
  import frame_sync_pkg::*;
#(
  parameter int MAX_LEN = 80,
  parameter int SCORE_W = score_w(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] window,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [MAX_LEN-1:0] mask,
  output logic [SCORE_W-1:0] s,
  output logic [SCORE_W-1:0] s_inv
);

  logic [SCORE_W-1:0] match_cnt;
  logic [SCORE_W-1:0] mask_cnt;

  always_comb begin
    match_cnt = '0;
    mask_cnt  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      match_cnt = match_cnt + SCORE_W'(mask[i] & (window[i] ~^ pattern[i]));
      mask_cnt  = mask_cnt + SCORE_W'(mask[i]);
    end
  end

  // Every masked position either matches or mismatches, so the inverted
  // score is the complement within the mask population.
  assign s     = match_cnt;
  assign s_inv = mask_cnt - match_cnt;

endmodule

// File: rtl/frame_sync.sv
// frame_sync
// Serial preamble detector and framer with hysteresis peak search.
//   clk, rst_n          : clock, async active-low reset
//   in_dat, in_vld      : hard-bit sample stream
//   cfg_pattern/mask    : preamble and participation mask (bit 0 = newest)
//   cfg_hi, cfg_lo      : detect threshold, peak-search exit threshold
//   cfg_payload_len     : payload bits per frame, latched at detection
//   cfg_inv_en          : allow inverted-polarity detection
//   out_dat/vld/sof/eof : polarity-corrected payload stream
//   detected            : one-cycle pulse when a frame is declared
//   inverted, peak_score: polarity and best score of current/last frame
//   busy                : high while in PEAK or PAYLOAD
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int MAX_LEN   = 80,
  parameter int SCORE_W   = score_w(MAX_LEN),
  parameter int PEAK_WIN  = 8,
  parameter int PAYLOAD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_dat,
  input  logic                 in_vld,
  input  logic [MAX_LEN-1:0]   cfg_pattern,
  input  logic [MAX_LEN-1:0]   cfg_mask,
  input  logic [SCORE_W-1:0]   cfg_hi,
  input  logic [SCORE_W-1:0]   cfg_lo,
  input  logic [PAYLOAD_W-1:0] cfg_payload_len,
  input  logic                 cfg_inv_en,
  output logic                 out_dat,
  output logic                 out_vld,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 detected,
  output logic                 inverted,
  output logic [SCORE_W-1:0]   peak_score,
  output logic                 busy
);

  localparam int CNT_W = $clog2(PEAK_WIN + 1);

  state_t               state;
  // Only the previous MAX_LEN-1 samples are stored; the current sample
  // completes the correlation window.
  logic [MAX_LEN-2:0]   hist;
  logic [PEAK_WIN-1:0]  dly;
  logic [SCORE_W-1:0]   fill_cnt;
  logic                 inv_lock;
  logic [SCORE_W-1:0]   best;
  logic [CNT_W-1:0]     peak_age;
  logic [CNT_W-1:0]     peak_cnt;
  logic [CNT_W-1:0]     wait_cnt;
  logic [PAYLOAD_W-1:0] rem;
  logic                 sof_pend;

  logic [MAX_LEN-1:0]   window;
  logic [SCORE_W-1:0]   s, s_inv;

  assign window = {hist, in_dat};

  frame_sync_corr #(
    .MAX_LEN (MAX_LEN),
    .SCORE_W (SCORE_W)
  ) u_corr (
    .window  (window),
    .pattern (cfg_pattern),
    .mask    (cfg_mask),
    .s       (s),
    .s_inv   (s_inv)
  );

  logic                 full;
  logic                 det_hit, det_inv;
  logic [SCORE_W-1:0]   det_score, score_lock, best_nxt;
  logic                 new_best, peak_exit;
  logic [CNT_W-1:0]     age_nxt, cnt_nxt;

  assign full       = fill_cnt >= SCORE_W'(MAX_LEN - 1);
  assign det_inv    = cfg_inv_en && (s_inv > s);
  assign det_score  = det_inv ? s_inv : s;
  assign det_hit    = full && ((s >= cfg_hi) || (cfg_inv_en && (s_inv >= cfg_hi)));

  assign score_lock = inv_lock ? s_inv : s;
  assign new_best   = score_lock > best;
  assign best_nxt   = new_best ? score_lock : best;
  // Samples elapsed since the peak, counting this one.
  assign age_nxt    = new_best ? '0 : peak_age + CNT_W'(1);
  assign cnt_nxt    = peak_cnt + CNT_W'(1);
  assign peak_exit  = (score_lock < cfg_lo) || (cnt_nxt == CNT_W'(PEAK_WIN));

  assign busy = (state != SEARCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      hist       <= '0;
      dly        <= '0;
      fill_cnt   <= '0;
      inv_lock   <= 1'b0;
      best       <= '0;
      peak_age   <= '0;
      peak_cnt   <= '0;
      wait_cnt   <= '0;
      rem        <= '0;
      sof_pend   <= 1'b0;
      out_dat    <= 1'b0;
      out_vld    <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      detected   <= 1'b0;
      inverted   <= 1'b0;
      peak_score <= '0;
    end else begin
      detected <= 1'b0;
      out_vld  <= 1'b0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
      if (in_vld) begin
        hist <= window[MAX_LEN-2:0];
        dly  <= {dly[PEAK_WIN-2:0], in_dat};
        if (fill_cnt != SCORE_W'(MAX_LEN)) fill_cnt <= fill_cnt + SCORE_W'(1);
        case (state)
          SEARCH: begin
            if (det_hit) begin
              state    <= PEAK;
              inv_lock <= det_inv;
              best     <= det_score;
              peak_age <= '0;
              peak_cnt <= '0;
            end
          end
          PEAK: begin
            best     <= best_nxt;
            peak_age <= age_nxt;
            peak_cnt <= cnt_nxt;
            if (peak_exit) begin
              detected   <= 1'b1;
              peak_score <= best_nxt;
              inverted   <= inv_lock;
              rem        <= cfg_payload_len;
              sof_pend   <= 1'b1;
              // Skip samples until the one after the peak reaches the
              // end of the delay line.
              wait_cnt   <= CNT_W'(PEAK_WIN) - age_nxt;
              state      <= (cfg_payload_len == '0) ? SEARCH : PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end else begin
              out_vld  <= 1'b1;
              out_dat  <= dly[PEAK_WIN-1] ^ inv_lock;
              out_sof  <= sof_pend;
              out_eof  <= (rem == PAYLOAD_W'(1));
              sof_pend <= 1'b0;
              rem      <= rem - PAYLOAD_W'(1);
              if (rem == PAYLOAD_W'(1)) state <= SEARCH;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync
// Scoreboard bench for frame_sync: stimulus pushes expected detections and
// payload bits into queues; a negedge monitor pops and compares.
module tb_frame_sync;

  localparam int MAX_LEN   = 80;
  localparam int SCORE_W   = 7;
  localparam int PEAK_WIN  = 8;
  localparam int PAYLOAD_W = 16;
  localparam logic [51:0] PRE = 52'hB38E5A91CD27F;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_dat = 1'b0;
  logic                 in_vld = 1'b0;
  logic [MAX_LEN-1:0]   cfg_pattern;
  logic [MAX_LEN-1:0]   cfg_mask;
  logic [SCORE_W-1:0]   cfg_hi;
  logic [SCORE_W-1:0]   cfg_lo;
  logic [PAYLOAD_W-1:0] cfg_payload_len;
  logic                 cfg_inv_en;
  logic                 out_dat, out_vld, out_sof, out_eof;
  logic                 detected, inverted, busy;
  logic [SCORE_W-1:0]   peak_score;

  always #5 clk = ~clk;

  frame_sync #(
    .MAX_LEN   (MAX_LEN),
    .SCORE_W   (SCORE_W),
    .PEAK_WIN  (PEAK_WIN),
    .PAYLOAD_W (PAYLOAD_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_dat          (in_dat),
    .in_vld          (in_vld),
    .cfg_pattern     (cfg_pattern),
    .cfg_mask        (cfg_mask),
    .cfg_hi          (cfg_hi),
    .cfg_lo          (cfg_lo),
    .cfg_payload_len (cfg_payload_len),
    .cfg_inv_en      (cfg_inv_en),
    .out_dat         (out_dat),
    .out_vld         (out_vld),
    .out_sof         (out_sof),
    .out_eof         (out_eof),
    .detected        (detected),
    .inverted        (inverted),
    .peak_score      (peak_score),
    .busy            (busy)
  );

  typedef struct packed {logic dat; logic sof; logic eof;} bit_t;
  typedef struct packed {logic inv; logic [SCORE_W-1:0] score;} det_t;

  bit_t exp_bits[$];
  det_t exp_det[$];
  int   checks = 0;
  int   errors = 0;
  int   bits_seen = 0;
  int   det_seen = 0;
  logic vld_prev = 1'b0;
  logic gap_en = 1'b0;
  logic pay  [0:99];
  logic pay0 [0:99];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) vld_prev <= in_vld;

  always @(negedge clk) begin
    if (rst_n) begin
      if (detected) begin
        det_t d;
        det_seen++;
        checks++;
        if (exp_det.size() == 0) begin
          errors++;
          $display("FAIL unexpected_detect score=%0d inv=%0d", peak_score, inverted);
        end else begin
          d = exp_det.pop_front();
          if (peak_score !== d.score || inverted !== d.inv) begin
            errors++;
            $display("FAIL detect actual score=%0d inv=%0d required score=%0d inv=%0d",
                     peak_score, inverted, d.score, d.inv);
          end
        end
      end
      if (out_vld) begin
        bit_t b;
        checks++;
        if (!vld_prev) begin
          errors++;
          $display("FAIL out_vld_after_gap actual=1 required=0");
        end
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_vld dat=%0d sof=%0d eof=%0d", out_dat, out_sof, out_eof);
        end else begin
          b = exp_bits.pop_front();
          if (out_dat !== b.dat || out_sof !== b.sof || out_eof !== b.eof) begin
            errors++;
            $display("FAIL payload_bit %0d actual dat/sof/eof=%0d%0d%0d required=%0d%0d%0d",
                     bits_seen, out_dat, out_sof, out_eof, b.dat, b.sof, b.eof);
          end
        end
        bits_seen++;
      end
    end
  end

  task automatic send_bit(input logic b);
    if (gap_en) begin
      while ($urandom_range(1, 0) == 0) begin
        in_vld = 1'b0;
        in_dat = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    in_vld = 1'b1;
    in_dat = b;
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic send_pre(input logic inv, input logic [51:0] flip);
    for (int i = 51; i >= 0; i--) send_bit(PRE[i] ^ flip[i] ^ inv);
  endtask

  task automatic send_zeros(input int n);
    repeat (n) send_bit(1'b0);
  endtask

  task automatic send_rand(input int n);
    repeat (n) send_bit(1'($urandom));
  endtask

  task automatic new_payload();
    for (int k = 0; k < 100; k++) pay[k] = 1'($urandom);
  endtask

  task automatic send_payload(input int len);
    for (int k = 0; k < len; k++) send_bit(pay[k]);
  endtask

  task automatic expect_frame(input logic inv, input int score, input int len);
    det_t d;
    bit_t b;
    d.inv   = inv;
    d.score = SCORE_W'(score);
    exp_det.push_back(d);
    for (int k = 0; k < len; k++) begin
      b.dat = pay[k] ^ inv;
      b.sof = (k == 0);
      b.eof = (k == len - 1);
      exp_bits.push_back(b);
    end
  endtask

  task automatic drain(input string name);
    check({name, "_bits_left"}, exp_bits.size(), 0);
    check({name, "_det_left"}, exp_det.size(), 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int det_base;
    int bit_base;
    cfg_pattern     = {28'hA5A5A5A, PRE};
    cfg_mask        = {28'h0, {52{1'b1}}};
    cfg_hi          = 7'd50;
    cfg_lo          = 7'd45;
    cfg_payload_len = 16'd100;
    cfg_inv_en      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vld", out_vld, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_out_dat", out_dat, 0);
    check("rst_detected", detected, 0);
    check("rst_inverted", inverted, 0);
    check("rst_peak_score", peak_score, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Normal frame
    new_payload();
    for (int k = 0; k < 100; k++) pay0[k] = pay[k];
    expect_frame(1'b0, 52, 100);
    send_rand(200);
    send_pre(1'b0, '0);
    send_payload(100);
    send_zeros(30);
    drain("normal");
    check("normal_det_count", det_seen, 1);
    check("normal_bit_count", bits_seen, 100);

    // Inverted preamble, inverted detection enabled
    cfg_inv_en      = 1'b1;
    cfg_payload_len = 16'd16;
    new_payload();
    expect_frame(1'b1, 52, 16);
    send_rand(100);
    send_pre(1'b1, '0);
    send_payload(16);
    send_zeros(30);
    drain("inv_en");
    check("inv_en_det_count", det_seen, 2);

    // Inverted preamble, inverted detection disabled
    cfg_inv_en = 1'b0;
    send_rand(50);
    send_pre(1'b1, '0);
    send_payload(16);
    send_zeros(30);
    drain("inv_dis");
    check("inv_dis_det_count", det_seen, 2);

    // Two flipped preamble bits: still detected at the threshold
    new_payload();
    expect_frame(1'b0, 50, 16);
    send_rand(60);
    send_pre(1'b0, (52'd1 << 5) | (52'd1 << 30));
    send_payload(16);
    send_zeros(30);
    drain("flip2");
    check("flip2_det_count", det_seen, 3);

    // Three flipped bits: below the threshold
    send_rand(60);
    send_pre(1'b0, (52'd1 << 5) | (52'd1 << 30) | (52'd1 << 47));
    send_zeros(30);
    drain("flip3");
    check("flip3_det_count", det_seen, 3);

    // Flow control: same payload as the normal frame, random gaps
    cfg_payload_len = 16'd100;
    for (int k = 0; k < 100; k++) pay[k] = pay0[k];
    gap_en = 1'b1;
    bit_base = bits_seen;
    expect_frame(1'b0, 52, 100);
    send_rand(100);
    send_pre(1'b0, '0);
    send_payload(100);
    send_zeros(30);
    gap_en = 1'b0;
    drain("gaps");
    check("gaps_bit_count", bits_seen - bit_base, 100);

    // Zero-length payload, back-to-back preambles
    cfg_payload_len = 16'd0;
    bit_base = bits_seen;
    det_base = det_seen;
    expect_frame(1'b0, 52, 0);
    expect_frame(1'b0, 52, 0);
    send_rand(100);
    send_pre(1'b0, '0);
    send_pre(1'b0, '0);
    send_zeros(30);
    drain("len0");
    check("len0_det_count", det_seen - det_base, 2);
    check("len0_bit_count", bits_seen - bit_base, 0);

    // Reset in the middle of a payload
    cfg_payload_len = 16'd100;
    new_payload();
    expect_frame(1'b0, 52, 100);
    send_rand(100);
    send_pre(1'b0, '0);
    bit_base = bits_seen;
    for (int k = 0; k < 100; k++) begin
      send_bit(pay[k]);
      if (bits_seen - bit_base == 40) break;
    end
    check("bits_before_reset", bits_seen - bit_base, 40);
    rst_n = 1'b0;
    #1;
    check("midrst_out_vld", out_vld, 0);
    check("midrst_out_sof", out_sof, 0);
    check("midrst_out_eof", out_eof, 0);
    check("midrst_out_dat", out_dat, 0);
    check("midrst_detected", detected, 0);
    check("midrst_inverted", inverted, 0);
    check("midrst_peak_score", peak_score, 0);
    check("midrst_busy", busy, 0);
    exp_bits.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    det_base = det_seen;
    send_zeros(20);
    send_pre(1'b0, '0);
    send_zeros(40);
    drain("postrst");
    check("postrst_det_count", det_seen - det_base, 0);
    check("postrst_peak_score", peak_score, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
